ahb_single_master: RTL and testbench
====================================

Name: ahb_single_master

Overview:
- AHB initiator that turns a simple command/response interface into single AHB transfers: one NONSEQ transfer per command, HBURST=SINGLE.
- It is the initiator side for the bus responders in this codebase (default/dummy slaves, memory and peripheral slaves).
- Handles HREADY wait states, two-cycle ERROR responses and RETRY/SPLIT re-issue.
- Used by boot/debug engines and test harnesses that need a register-style bus port. Single master, bus always granted, no arbitration.

Parameters:
- MAX_RETRY, 4: number of RETRY/SPLIT re-issues allowed before the command completes with an error.
- TIMEOUT_CYCLES, 256: HREADY-low watchdog limit. Used only with AHB_MST_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a HCLK edge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  HSIZE encoding; only 000/001/010 are legal.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_err  out  1  completion was an error. Qualified by rsp_valid.
- rsp_rdata  out  32  read data. Qualified by rsp_valid && !cmd_write of that command.
- HADDR  out  32  address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant 000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  write data, driven in the data phase.
- HREADY  in  1  transfer done / wait.
- HRESP  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
- HRDATA  in  32  read data.

Behaviour:
- Clocking and reset: single clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, HADDR=0, HTRANS=00, HWRITE=0, HSIZE=000, HWDATA=0; state=IDLE, retry count=0.
- Reset mid-transfer: all outputs take their reset values immediately; the in-flight command is dropped with no response.
- Outputs are registered. States: IDLE, ADDR, DATA.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch the command. Drive HADDR/HWRITE/HSIZE from it and HTRANS=NONSEQ. Go to ADDR. retry count=0.
- ADDR:
  - cmd_ready=0.
  - Edge with HREADY=1: address phase done. HTRANS<=IDLE; HWDATA<=latched wdata for writes (hold otherwise). Go to DATA.
  - Edge with HREADY=0: hold all address/control outputs.
- DATA:
  - HREADY=0: wait. HRESP in this cycle is the first cycle of a two-cycle response and causes no action.
  - HREADY=1, HRESP=OKAY: rsp_valid=1 next cycle, rsp_err=0, rsp_rdata<=HRDATA for reads. Go to IDLE.
  - HREADY=1, HRESP=ERROR: rsp_valid=1, rsp_err=1, rsp_rdata unchanged. Go to IDLE.
  - HREADY=1, HRESP=RETRY or SPLIT:
    - If retry count < MAX_RETRY: increment it, re-drive the same NONSEQ transfer next cycle, go to ADDR.
    - Else: rsp_valid=1, rsp_err=1. Go to IDLE.
- Latency, zero wait states, OKAY:
  - Handshake at edge E0; NONSEQ visible after E0.
  - Address phase completes at E1; data phase completes at E2.
  - rsp_valid high for the cycle after E2.
  - Each wait state adds one cycle; each retry adds two cycles plus waits.
- Back-to-back: cmd_ready is high in the same cycle as rsp_valid, so the next command can be accepted then. Commands never overlap, so there is no pipelining of address and data phases.
- Illegal cmd_size (>010): the command is accepted, completes immediately with rsp_err=1, and no bus transfer is issued.
- Unaligned address for the given size: passed through unchanged; the slave decides.

Optional Feature:
- Macro: AHB_MST_TIMEOUT_EN.
- Defined:
  - A counter increments on each DATA cycle with HREADY=0 and clears on HREADY=1 or on leaving DATA.
  - When it reaches TIMEOUT_CYCLES: rsp_valid=1, rsp_err=1, state<=IDLE, HTRANS stays IDLE. The transfer is abandoned and treated as a bus fault.
- Not defined: no counter is built and DATA waits on HREADY indefinitely.

Test Plan:
- Read cmd addr 0x0000_0010, size 010; slave zero-wait OKAY, HRDATA=0xDEAD_BEEF -> HTRANS=10 one cycle, HBURST=000, rsp_valid 3 cycles after handshake, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write addr 0x0000_0020, wdata 0x1234_5678; slave inserts 2 HREADY-low cycles in the data phase -> HWDATA=0x1234_5678 held through the data phase, rsp_valid at cycle 5, rsp_err=0.
- Two-cycle ERROR (HREADY=0/HRESP=01, then HREADY=1/HRESP=01) on a read -> one rsp_valid with rsp_err=1, rsp_rdata unchanged, return to IDLE, next command accepted.
- RETRY returned 5 times with MAX_RETRY=4 -> exactly 5 NONSEQ transfers to the same HADDR, then rsp_err=1. A RETRY on the 3rd attempt followed by OKAY on the 4th -> rsp_err=0.
- HRESETn asserted while in DATA -> HTRANS=00, cmd_ready=0, rsp_valid=0 immediately; after release, no response for the dropped command, and cmd_ready=1 one cycle later.
- With AHB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave holds HREADY=0 -> rsp_valid with rsp_err=1 after 8 wait cycles. Without the macro -> no response.

Source files
------------

// File: rtl/ahb_single_master.sv
// Single-transfer AHB initiator: one NONSEQ/SINGLE transfer per command, with wait-state,
// ERROR and RETRY/SPLIT handling. Optional data-phase watchdog: define AHB_MST_TIMEOUT_EN.
module ahb_single_master #(
  parameter int MAX_RETRY      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic [31:0]   r_haddr;
  logic [1:0]    r_htrans;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [31:0]   r_hwdata;
  logic [31:0]   r_wdata;
  logic [RW-1:0] r_retry_cnt;

`ifdef AHB_MST_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_to_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_haddr     <= '0;
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_retry_cnt <= '0;
`ifdef AHB_MST_TIMEOUT_EN
      r_to_cnt    <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            // Illegal sizes never reach the bus; they complete as an error in place.
            if (cmd_size > 3'b010) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_cmd_ready <= 1'b0;
              r_haddr     <= cmd_addr;
              r_hwrite    <= cmd_write;
              r_hsize     <= cmd_size;
              r_wdata     <= cmd_wdata;
              r_htrans    <= TR_NONSEQ;
              r_retry_cnt <= '0;
              r_state     <= ST_ADDR;
            end
          end
        end

        ST_ADDR: begin
          r_cmd_ready <= 1'b0;
          if (HREADY) begin
            r_htrans <= TR_IDLE;
            if (r_hwrite) begin
              r_hwdata <= r_wdata;
            end
            r_state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (HREADY) begin
`ifdef AHB_MST_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            case (HRESP)
              2'b00: begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                if (!r_hwrite) begin
                  r_rsp_rdata <= HRDATA;
                end
                r_cmd_ready <= 1'b1;
                r_state     <= ST_IDLE;
              end
              2'b01: begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_cmd_ready <= 1'b1;
                r_state     <= ST_IDLE;
              end
              default: begin
                // RETRY and SPLIT both re-issue the identical transfer until the budget runs out.
                if (r_retry_cnt < RW'(MAX_RETRY)) begin
                  r_retry_cnt <= r_retry_cnt + 1'b1;
                  r_htrans    <= TR_NONSEQ;
                  r_state     <= ST_ADDR;
                end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
                end
              end
            endcase
          end
`ifdef AHB_MST_TIMEOUT_EN
          else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_to_cnt    <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HWDATA    = r_hwdata;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_single_master.sv
// Bench for ahb_single_master: scripted AHB slave on the bus side, response scoreboard
// on the command side, one task per scenario.
module tb_ahb_single_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  ahb_single_master #(.MAX_RETRY(4), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {int waits; logic [1:0] resp; logic [31:0] rdata;} slv_t;
  typedef struct {logic err; logic [31:0] rdata;} exp_t;

  slv_t        slave_q[$];
  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  int          nonseq_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = 32'h0;

  // Slave: decides HREADY/HRESP for the coming edge on each falling edge.
  int          s_waits;
  logic [1:0]  s_resp;
  logic [31:0] s_rdata;
  bit          s_in_data = 1'b0;
  bit          s_first_done;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      s_in_data = 1'b0;
      HREADY = 1'b1;
      HRESP = 2'b00;
      HRDATA = 32'h0;
    end else begin
      if (s_in_data) begin
        if (s_waits > 0) begin
          HREADY = 1'b0; HRESP = 2'b00; HRDATA = 32'h0BAD_0BAD;
          s_waits--;
        end else if (s_resp != 2'b00 && !s_first_done) begin
          HREADY = 1'b0; HRESP = s_resp; HRDATA = 32'h0BAD_0BAD;
          s_first_done = 1'b1;
        end else begin
          HREADY = 1'b1; HRESP = s_resp; HRDATA = s_rdata;
          s_in_data = 1'b0;
        end
      end else begin
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0BAD_0BAD;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        slv_t e;
        e = '{0, 2'b00, 32'h0};
        if (slave_q.size() > 0) e = slave_q.pop_front();
        nonseq_cnt++;
        addr_log.push_back(HADDR);
        s_in_data = 1'b1;
        s_waits = e.waits;
        s_resp = e.resp;
        s_rdata = e.rdata;
        s_first_done = 1'b0;
      end
    end
  end

  // Scoreboard: every response pulse is matched against the oldest expectation.
  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b required no response", rsp_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 2;
        if (rsp_err !== e.err) begin
          errors++;
          $display("FAIL rsp_err: got %0b required %0b", rsp_err, e.err);
        end
        if (rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
    cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic pulse_reset();
    HRESETn = 1'b0;
    slave_q.delete();
    model_rdata = 32'h0;
    tick(); tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    tick(); tick();
    checks += 6;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b required 0", rsp_valid); end
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b required 00", HTRANS); end
    if ({HADDR, HWDATA, rsp_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h required 0", HADDR, HWDATA, rsp_rdata); end
    if ({HWRITE, HSIZE, rsp_err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 00000", {HWRITE, HSIZE, rsp_err}); end
    if ({HBURST, HMASTLOCK} !== 4'b0) begin errors++; $display("FAIL reset_burst_lock: got %b required 0000", {HBURST, HMASTLOCK}); end
    HRESETn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b required 1", cmd_ready); end
  endtask

  // Latencies below count edges after the handshake edge until rsp_valid is visible.
  task automatic test_read_okay();
    int cyc;
    slave_q.push_back('{0, 2'b00, 32'hDEAD_BEEF});
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    model_rdata = 32'hDEAD_BEEF;
    send_cmd(1'b0, 32'h0000_0010, 3'b010, 32'h0);
    checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST} !== {2'b10, 32'h10, 1'b0, 3'b010, 3'b000}) begin
      errors++; $display("FAIL read_addr_phase: got %b %h %b %b %b required 10 00000010 0 010 000", HTRANS, HADDR, HWRITE, HSIZE, HBURST);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick(); cyc++;
      if (cyc == 1) begin
        checks++;
        if (HTRANS !== 2'b00) begin errors++; $display("FAIL read_htrans_one_cycle: got %b required 00", HTRANS); end
      end
    end
    checks += 2;
    if (cyc != 2) begin errors++; $display("FAIL read_latency: got %0d required 2", cyc); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL read_ready_with_rsp: got %0b required 1", cmd_ready); end
  endtask

  task automatic test_write_wait();
    int cyc;
    slave_q.push_back('{2, 2'b00, 32'h0});
    exp_q.push_back('{1'b0, model_rdata});
    send_cmd(1'b1, 32'h0000_0020, 3'b010, 32'h1234_5678);
    checks++;
    if ({HTRANS, HWRITE} !== 3'b101) begin errors++; $display("FAIL write_addr_phase: got %b required 101", {HTRANS, HWRITE}); end
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick(); cyc++;
      if (!rsp_valid) begin
        checks++;
        if (HWDATA !== 32'h1234_5678) begin errors++; $display("FAIL write_hwdata_hold: got %h required 12345678", HWDATA); end
      end
    end
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL write_latency: got %0d required 4", cyc); end
  endtask

  task automatic test_error();
    int cyc;
    slave_q.push_back('{0, 2'b01, 32'hFFFF_0000});
    exp_q.push_back('{1'b1, model_rdata});
    send_cmd(1'b0, 32'h0000_0030, 3'b001, 32'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin tick(); cyc++; end
    checks += 2;
    if (cyc != 3) begin errors++; $display("FAIL error_latency: got %0d required 3", cyc); end
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL error_ready_after: got %0b required 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    slave_q.push_back('{0, 2'b00, 32'h0});
    exp_q.push_back('{1'b0, model_rdata});
    send_cmd(1'b1, 32'h0000_0050, 3'b000, 32'hCAFE_0001);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (!(rsp_valid && cmd_ready)) begin errors++; $display("FAIL b2b_ready_with_rsp: got valid=%0b ready=%0b required 1 1", rsp_valid, cmd_ready); end
    slave_q.push_back('{0, 2'b00, 32'h5555_AAAA});
    exp_q.push_back('{1'b0, 32'h5555_AAAA});
    model_rdata = 32'h5555_AAAA;
    send_cmd(1'b0, 32'h0000_0054, 3'b010, 32'h0);
    checks++;
    if ({HTRANS, HADDR, rsp_valid} !== {2'b10, 32'h54, 1'b0}) begin
      errors++; $display("FAIL b2b_second_nonseq: got %b %h %b required 10 00000054 0", HTRANS, HADDR, rsp_valid);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL b2b_latency: got %0d required 2", cyc); end
  endtask

  task automatic test_retry();
    int cyc;
    int bad;
    addr_log.delete();
    for (int i = 0; i < 5; i++) slave_q.push_back('{0, 2'b10, 32'h0});
    exp_q.push_back('{1'b1, model_rdata});
    send_cmd(1'b0, 32'h0000_0060, 3'b010, 32'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 32'h60) bad++;
    checks += 3;
    if (cyc != 15) begin errors++; $display("FAIL retry_exhaust_latency: got %0d required 15", cyc); end
    if (addr_log.size() != 5) begin errors++; $display("FAIL retry_exhaust_count: got %0d required 5", addr_log.size()); end
    if (bad != 0) begin errors++; $display("FAIL retry_same_addr: got %0d wrong addresses required 0", bad); end

    addr_log.delete();
    slave_q.push_back('{0, 2'b10, 32'h0});
    slave_q.push_back('{0, 2'b11, 32'h0});
    slave_q.push_back('{0, 2'b10, 32'h0});
    slave_q.push_back('{0, 2'b00, 32'h600D_F00D});
    exp_q.push_back('{1'b0, 32'h600D_F00D});
    model_rdata = 32'h600D_F00D;
    send_cmd(1'b0, 32'h0000_0064, 3'b010, 32'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin tick(); cyc++; end
    checks += 2;
    if (cyc != 11) begin errors++; $display("FAIL retry_recover_latency: got %0d required 11", cyc); end
    if (addr_log.size() != 4) begin errors++; $display("FAIL retry_recover_count: got %0d required 4", addr_log.size()); end
  endtask

  task automatic test_illegal_size();
    int n0;
    n0 = nonseq_cnt;
    exp_q.push_back('{1'b1, model_rdata});
    send_cmd(1'b0, 32'h0000_0070, 3'b100, 32'h0);
    checks += 2;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL illegal_immediate_rsp: got %0b required 1", rsp_valid); end
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL illegal_no_nonseq: got %b required 00", HTRANS); end
    tick(); tick(); tick();
    checks++;
    if (nonseq_cnt != n0) begin errors++; $display("FAIL illegal_bus_transfers: got %0d required 0", nonseq_cnt - n0); end
  endtask

  task automatic test_reset_mid();
    int seen;
    slave_q.push_back('{1000, 2'b00, 32'h0});
    send_cmd(1'b0, 32'h0000_0080, 3'b010, 32'h0);
    tick(); tick();
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HTRANS, cmd_ready, rsp_valid, HADDR} !== 36'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got htrans=%b ready=%0b valid=%0b haddr=%h required all 0", HTRANS, cmd_ready, rsp_valid, HADDR);
    end
    slave_q.delete();
    model_rdata = 32'h0;
    tick(); tick();
    HRESETn = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %0b required 1", cmd_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_dropped: got %0d responses required 0", seen); end
  endtask

  task automatic test_timeout();
    int cyc;
    slave_q.push_back('{1000, 2'b00, 32'h0});
`ifdef AHB_MST_TIMEOUT_EN
    exp_q.push_back('{1'b1, model_rdata});
`endif
    send_cmd(1'b0, 32'h0000_0090, 3'b010, 32'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin tick(); cyc++; end
`ifdef AHB_MST_TIMEOUT_EN
    checks += 2;
    if (cyc != 9) begin errors++; $display("FAIL timeout_latency: got %0d required 9", cyc); end
    if (HTRANS !== 2'b00) begin errors++; $display("FAIL timeout_htrans: got %b required 00", HTRANS); end
`else
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_timeout_rsp: got %0b required 0", rsp_valid); end
`endif
    pulse_reset();
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'b000; cmd_wdata = 32'h0;
    test_reset();
    test_read_okay();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_retry();
    test_illegal_size();
    test_reset_mid();
    test_timeout();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_rsp: got %0d outstanding required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
